// File: rtl/leaf_uplink_arbiter.sv
// leaf_uplink_arbiter: per-source FIFOs round-robin arbitrated onto a credit-controlled spine uplink.
// Define LEAF_UPLINK_STATS_EN to build per-source saturating sent-flit counters.
module leaf_uplink_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC*DWIDTH-1:0]    src_data,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [DWIDTH-1:0]            up_data,
    output logic                         up_valid,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         credit_err,
    output logic [1:0]                   arb_state,
    input  logic [$clog2(NUM_SRC)-1:0]   stat_sel,
    output logic [15:0]                  stat_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(CREDITS + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STALL = 2'd2} state_t;
    state_t state, state_d;
    logic [DWIDTH-1:0] mem [NUM_SRC][FIFO_DEPTH];
    logic [AW:0] wr_ptr [NUM_SRC];
    logic [AW:0] rd_ptr [NUM_SRC];
    logic [AW:0] wr_ptr_d [NUM_SRC];
    logic [AW:0] rd_ptr_d [NUM_SRC];
    logic [NUM_SRC-1:0] empty, empty_d, push, pop;
    logic [SW-1:0] rr_ptr, gnt_idx, cand;
    logic found, grant;
    logic [CW-1:0] credit_d;
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            empty[i] = wr_ptr[i] == rd_ptr[i];
            src_ready[i] = (wr_ptr[i] - rd_ptr[i]) != (AW+1)'(FIFO_DEPTH);
        end
    end
    // Round-robin search starts just after the last granted source.
    always_comb begin
        found = 1'b0;
        gnt_idx = rr_ptr;
        cand = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                gnt_idx = cand;
            end
        end
    end
    assign grant = found && credit_cnt != '0;
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            push[i] = src_valid[i] && src_ready[i];
            pop[i] = grant && gnt_idx == SW'(i);
            wr_ptr_d[i] = wr_ptr[i] + (AW+1)'(push[i]);
            rd_ptr_d[i] = rd_ptr[i] + (AW+1)'(pop[i]);
            empty_d[i] = wr_ptr_d[i] == rd_ptr_d[i];
        end
        credit_d = (grant && !credit_return) ? credit_cnt - CW'(1)
                 : (!grant && credit_return && credit_cnt != CW'(CREDITS)) ? credit_cnt + CW'(1)
                 : credit_cnt;
        // State tracks what the next cycle will do: SEND exactly when a grant is possible.
        state_d = &empty_d ? IDLE : credit_d != '0 ? SEND : STALL;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++)
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= src_data[i*DWIDTH +: DWIDTH];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            up_data <= '0;
            up_valid <= 1'b0;
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
            rr_ptr <= SW'(NUM_SRC - 1);
            state <= IDLE;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= wr_ptr_d[i];
                rd_ptr[i] <= rd_ptr_d[i];
            end
            up_valid <= grant;
            if (grant) begin
                up_data <= mem[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
                rr_ptr <= gnt_idx;
            end
            credit_cnt <= credit_d;
            if (credit_return && !grant && credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
            state <= state_d;
        end
    end
    assign arb_state = state;
`ifdef LEAF_UPLINK_STATS_EN
    logic [15:0] stat [NUM_SRC];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) stat[i] <= '0;
        end else if (grant && stat[gnt_idx] != 16'hFFFF) begin
            stat[gnt_idx] <= stat[gnt_idx] + 16'd1;
        end
    end
    assign stat_count = stat[stat_sel];
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count = 16'h0;
`endif
endmodule
